// File: rtl/readout_sequencer_if.sv
// readout_sequencer_if: sensor/pixel-array/buffer signals of the readout sequencer
interface readout_sequencer_if #(parameter int ROWS = 2);
  logic START, BUFFER_BUSY;
  logic [ROWS-1:0] ROW_SELECT;
  logic ROW_READ, SET_BUFFER, BUSY, FRAME_DONE, ERROR;
  modport master(input START, BUFFER_BUSY, output ROW_SELECT, ROW_READ, SET_BUFFER, BUSY, FRAME_DONE, ERROR);
  modport slave(output START, BUFFER_BUSY, input ROW_SELECT, ROW_READ, SET_BUFFER, BUSY, FRAME_DONE, ERROR);
endinterface

// File: rtl/readout_sequencer.sv
// readout_sequencer: row-by-row frame readout (select, settle, load buffer, drain).
// Define SYNC_START_EN to pass START through a two-flop synchronizer.
module readout_sequencer #(
  parameter int ROWS = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input logic CLK,
  input logic RESET,
  readout_sequencer_if.master bus
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, WAIT_ACK, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [ROWS-1:0] row_select_q, row_select_d;
  logic error_q, error_d, row_read_q, row_read_d, set_buffer_q, set_buffer_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d;
  logic start;
`ifdef SYNC_START_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], bus.START};
  assign start = sync_q[1];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sync_q <= '0;
    else sync_q <= sync_d;
`else
  assign start = bus.START;
`endif
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    settle_d = settle_q;
    tmo_d = tmo_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        row_d = '0;
        if (start) begin
          state_d = SELECT;
          settle_d = '0;
          error_d = 1'b0;
        end
      end
      SELECT: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = LOAD;
      end
      LOAD: begin
        state_d = WAIT_ACK;
        tmo_d = '0;
      end
      WAIT_ACK:
        if (bus.BUFFER_BUSY) state_d = DRAIN;
        else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else tmo_d = tmo_q + TW'(1);
      DRAIN:
        if (!bus.BUFFER_BUSY) begin
          if (row_q == RW'(ROWS - 1)) state_d = DONE;
          else begin
            state_d = SELECT;
            row_d = row_q + RW'(1);
            settle_d = '0;
          end
        end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so they register alongside it
    row_read_d = state_d inside {SELECT, LOAD, WAIT_ACK};
    row_select_d = row_read_d ? ROWS'(1) << row_d : '0;
    set_buffer_d = state_d == LOAD;
    busy_d = state_d != IDLE;
    frame_done_d = state_d == DONE;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      row_q <= '0;
      settle_q <= '0;
      tmo_q <= '0;
      error_q <= 1'b0;
      row_select_q <= '0;
      row_read_q <= 1'b0;
      set_buffer_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      settle_q <= settle_d;
      tmo_q <= tmo_d;
      error_q <= error_d;
      row_select_q <= row_select_d;
      row_read_q <= row_read_d;
      set_buffer_q <= set_buffer_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
    end
  assign bus.ROW_SELECT = row_select_q;
  assign bus.ROW_READ = row_read_q;
  assign bus.SET_BUFFER = set_buffer_q;
  assign bus.BUSY = busy_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.ERROR = error_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: directed frames against a cycle-level readout model
module tb_readout_sequencer;
  localparam int ROWS = 2, SETTLE = 2, ACK = 4;
  logic clk = 0, rst_n = 1;
  int n_tests = 0, n_fail = 0, cyc = 0;
  bit buf_mode = 0;
  int set_q[$], sel_q[$], fd_q[$], rr_q[$], err_q[$];
  int n_set, n_fd, n_rr, n_err, t0, t1;
  bit rr_prev = 0, err_prev = 0;
  bit m_active, m_done, m_err;
  int m_row, m_t;
  readout_sequencer_if #(.ROWS(ROWS)) b();
  readout_sequencer #(.ROWS(ROWS), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK)) dut (
    .CLK(clk), .RESET(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic mark();
    n_set = set_q.size(); n_fd = fd_q.size(); n_rr = rr_q.size(); n_err = err_q.size(); t0 = cyc;
  endtask
  // m_t counts cycles since the row's ROW_READ rose; -1 means the row is draining
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_active <= 0; m_done <= 0; m_err <= 0; m_row <= 0; m_t <= 0;
    end else if (m_done) m_done <= 0;
    else if (!m_active) begin
      if (b.START) begin m_active <= 1; m_row <= 0; m_t <= 0; m_err <= 0; end
    end else if (m_t < 0) begin
      if (!b.BUFFER_BUSY) begin
        if (m_row == ROWS - 1) begin m_active <= 0; m_done <= 1; end
        else begin m_row <= m_row + 1; m_t <= 0; end
      end
    end else if (m_t > SETTLE && b.BUFFER_BUSY) m_t <= -1;
    else if (m_t == SETTLE + ACK) begin m_active <= 0; m_err <= 1; end
    else m_t <= m_t + 1;
  always @(negedge clk) begin
    automatic bit rd = m_active && m_t >= 0;
    check("row_read", b.ROW_READ, rd);
    check("row_select", b.ROW_SELECT, rd ? (1 << m_row) : 0);
    check("set_buffer", b.SET_BUFFER, rd && m_t == SETTLE);
    check("busy", b.BUSY, m_active || m_done);
    check("frame_done", b.FRAME_DONE, m_done);
    check("error", b.ERROR, m_err);
    if (b.SET_BUFFER) begin set_q.push_back(cyc); sel_q.push_back(int'(b.ROW_SELECT)); end
    if (b.FRAME_DONE) fd_q.push_back(cyc);
    if (b.ROW_READ && !rr_prev) rr_q.push_back(cyc);
    if (b.ERROR && !err_prev) err_q.push_back(cyc);
    rr_prev = b.ROW_READ;
    err_prev = b.ERROR;
  end
  // output buffer: busy 2 cycles after SET_BUFFER, for 4 cycles
  initial begin
    b.BUFFER_BUSY = 0;
    forever begin
      @(negedge clk);
      if (buf_mode && b.SET_BUFFER) begin
        @(posedge clk);
        @(posedge clk);
        #1 b.BUFFER_BUSY = 1;
        repeat (4) @(posedge clk);
        #1 b.BUFFER_BUSY = 0;
      end
    end
  end
  initial begin
    b.START = 0;
    #1 rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(2);
    check("rst_busy", b.BUSY, 0);
    check("rst_err", b.ERROR, 0);
    check("rst_sel", b.ROW_SELECT, 0);
    buf_mode = 1;
    mark();
    b.START = 1; tick(1); b.START = 0;
    tick(25);
    check("nom_sets", set_q.size() - n_set, 2);
    check("nom_sel0", sel_q[n_set], 1);
    check("nom_sel1", sel_q[n_set + 1], 2);
    check("nom_set0_cyc", set_q[n_set] - t0, 3);
    check("nom_set1_cyc", set_q[n_set + 1] - t0, 12);
    check("nom_rr0_cyc", rr_q[n_rr] - t0, 1);
    check("nom_rr1_cyc", rr_q[n_rr + 1] - t0, 10);
    check("nom_fd_n", fd_q.size() - n_fd, 1);
    check("nom_fd_cyc", fd_q[n_fd] - t0, 19);
    buf_mode = 0;
    mark();
    b.START = 1; tick(1); b.START = 0;
    tick(12);
    check("to_err_cyc", err_q[n_err] - t0, 8);
    check("to_fd_n", fd_q.size() - n_fd, 0);
    check("to_sets", set_q.size() - n_set, 1);
    check("to_busy", b.BUSY, 0);
    check("to_err", b.ERROR, 1);
    buf_mode = 1;
    b.START = 1; tick(1); b.START = 0;
    check("err_clr", b.ERROR, 0);
    tick(25);
    mark();
    b.START = 1; tick(1); b.START = 0;
    tick(6);
    b.START = 1; tick(1); b.START = 0;
    tick(17);
    check("ign_sets", set_q.size() - n_set, 2);
    check("ign_fd_n", fd_q.size() - n_fd, 1);
    check("ign_fd_cyc", fd_q[n_fd] - t0, 19);
    b.START = 1; tick(1); b.START = 0;
    tick(2);
    check("mid_pre_set", b.SET_BUFFER, 1);
    #2 rst_n = 0;
    #1;
    check("mid_set", b.SET_BUFFER, 0);
    check("mid_rr", b.ROW_READ, 0);
    check("mid_sel", b.ROW_SELECT, 0);
    check("mid_busy", b.BUSY, 0);
    b.START = 1;
    tick(1);
    rst_n = 1;
    mark();
    tick(1);
    b.START = 0;
    tick(25);
    check("mid_rr_cyc", rr_q[n_rr] - t0, 1);
    check("mid_sel0", sel_q[n_set], 1);
    check("mid_fd_n", fd_q.size() - n_fd, 1);
    mark();
    b.START = 1; tick(22); b.START = 0;
    tick(25);
    check("b2b_fd_n", fd_q.size() - n_fd, 2);
    check("b2b_fd_gap", fd_q[n_fd + 1] - fd_q[n_fd], 20);
    check("b2b_rr_gap", rr_q[n_rr + 2] - fd_q[n_fd], 2);
    check("b2b_sets", set_q.size() - n_set, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
